// File: rtl/bus_timer_if.sv
// Data-bus port between the CPU M-stage access and the bus_timer responder.
// The master drives the access; the slave returns combinational rdata and irq.
interface bus_timer_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, wdata, we, be, input rdata, irq);
    modport slave  (input addr, wdata, we, be, output rdata, irq);
endinterface

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped countdown timer on the CPU data bus, irq on terminal count.
// Optional count prescaler is enabled by defining BUS_TIMER_PRESCALE_EN.
//
// state | meaning
// IDLE  | stopped, COUNT holds its last value
// LOAD  | COUNT takes PRESET
// CNT   | counting down, one step per tick
// INT   | terminal count reached, pending set
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          PRESCALE  = 4
) (
    input logic        clk,
    input logic        reset,
    bus_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state;
    logic        en;
    logic        im;
    logic [1:0]  mode;
    logic        pending;
    logic [31:0] preset;
    logic [31:0] count;

    logic        sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        tick;
    logic        expire;
    logic [3:0]  ctrl_next;
    logic [31:0] preset_next;
    logic        unused_addr;

    assign sel         = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign wr_ctrl     = bus.we & sel & (bus.addr[3:2] == 2'd0);
    assign wr_preset   = bus.we & sel & (bus.addr[3:2] == 2'd1);
    assign unused_addr = ^bus.addr[1:0];

    // Only byte 0 of CTRL holds writable bits.
    assign ctrl_next = bus.be[0] ? bus.wdata[3:0] : {im, mode, en};

    always_comb begin
        preset_next = preset;
        for (int i = 0; i < 4; i++) begin
            if (bus.be[i]) preset_next[8*i +: 8] = bus.wdata[8*i +: 8];
        end
    end

`ifdef BUS_TIMER_PRESCALE_EN
    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= PRESC_LAST;
        end else if (state == CNT && presc != '0) begin
            presc <= presc - PW'(1);
        end else begin
            presc <= PRESC_LAST;
        end
    end

    assign tick = (state == CNT) && (presc == '0);
`else
    logic unused_cfg;

    assign unused_cfg = (PRESCALE >= 1);
    assign tick       = 1'b1;
`endif

    // A zero count expires without waiting for a tick.
    assign expire = (count == 32'd0) || ((count == 32'd1) && tick);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            en      <= 1'b0;
            mode    <= 2'b00;
            im      <= 1'b0;
            pending <= 1'b0;
            preset  <= 32'd0;
            count   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (expire) begin
                        count   <= 32'd0;
                        pending <= 1'b1;
                        state   <= INT;
                    end else if (tick) begin
                        count <= count - 32'd1;
                    end
                end
                INT: begin
                    if (mode == 2'b01) begin
                        pending <= 1'b0;
                        state   <= LOAD;
                    end else begin
                        en    <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wr_preset) preset <= preset_next;

            // A CPU CTRL write takes precedence over anything the FSM did this edge.
            if (wr_ctrl) begin
                en      <= ctrl_next[0];
                mode    <= ctrl_next[2:1];
                im      <= ctrl_next[3];
                pending <= 1'b0;
                if (!ctrl_next[0]) begin
                    state <= IDLE;
                    count <= count;
                end
            end
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        if (sel) begin
            case (bus.addr[3:2])
                2'd0:    bus.rdata = {28'd0, im, mode, en};
                2'd1:    bus.rdata = preset;
                2'd2:    bus.rdata = count;
                default: bus.rdata = 32'd0;
            endcase
        end
    end

    assign bus.irq = pending & im;

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: directed timing scenarios plus random bus traffic,
// all compared against a behavioural model of the timer kept here.
module tb_bus_timer;
    localparam logic [31:0] B = 32'h0000_7F00;
`ifdef BUS_TIMER_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif
    localparam int PH_IDLE    = 0;
    localparam int PH_RELOAD  = 1;
    localparam int PH_COUNT   = 2;
    localparam int PH_EXPIRED = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    bus_timer_if bus ();

    bus_timer #(.BASE_ADDR(B), .PRESCALE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model of the programmer-visible timer
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_pend;
    int          m_phase;
    int          m_age;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:4] != B[31:4]) return 32'd0;
        case (a[3:2])
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
        m_pend = 1'b0; m_phase = PH_IDLE; m_age = 0;
    endtask

    task automatic model_step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        logic        hit;
        logic        ticked;
        logic [31:0] cw;
        int          ph;
        int          age;
        logic [31:0] cnt;
        logic        pend;
        logic [3:0]  ctl;
        hit    = w && (a[31:4] == B[31:4]);
        ticked = ((m_age + 1) % P) == 0;
        ph = m_phase; age = m_age; cnt = m_count; pend = m_pend; ctl = m_ctrl;
        if (m_phase == PH_IDLE) begin
            if (m_ctrl[0]) ph = PH_RELOAD;
        end else if (m_phase == PH_RELOAD) begin
            cnt = m_preset; ph = PH_COUNT; age = 0;
        end else if (m_phase == PH_COUNT) begin
            if (!m_ctrl[0]) ph = PH_IDLE;
            else if (m_count == 0 || (m_count == 1 && ticked)) begin
                cnt = 0; pend = 1'b1; ph = PH_EXPIRED;
            end else begin
                if (ticked) cnt = m_count - 1;
                age = m_age + 1;
            end
        end else begin
            if (m_ctrl[2:1] == 2'b01) begin ph = PH_RELOAD; pend = 1'b0; end
            else begin ph = PH_IDLE; ctl[0] = 1'b0; end
        end
        if (hit && a[3:2] == 2'd1) m_preset = merge(m_preset, d, b);
        if (hit && a[3:2] == 2'd0) begin
            cw = merge({28'd0, m_ctrl}, d, b);
            ctl = cw[3:0]; pend = 1'b0;
            if (!cw[0]) begin ph = PH_IDLE; cnt = m_count; end
        end
        m_phase = ph; m_age = age; m_count = cnt; m_pend = pend; m_ctrl = ctl;
    endtask

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b;
        #1;
        check_eq("rdata", bus.rdata, model_read(a));
        check_eq("irq", {31'd0, bus.irq}, {31'd0, m_pend & m_ctrl[3]});
        @(posedge clk);
        model_step(w, a, d, b);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, a, d, 4'hF);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, B + 32'd8, 32'd0, 4'h0);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.we = 1'b0; bus.addr = a;
        #1;
        check_eq(tag, bus.rdata, exp);
    endtask

    int pulses[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.we = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0; bus.be = 4'h0;
        model_reset();
        #2;
        check_eq("rst_irq", {31'd0, bus.irq}, 32'd0);
        rd_check("rst_ctrl", B, 32'd0);
        rd_check("rst_preset", B + 32'd4, 32'd0);
        rd_check("rst_count", B + 32'd8, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // one-shot, PRESET=5: edge 0 is the CTRL write
        wr(B, 32'd0); wr(B + 32'd4, 32'd5); wr(B, 32'h9);
        idle(2);
        rd_check("t2_count_loaded", B + 32'd8, 32'd5);
        idle(5 * P - 1);
        check_eq("t2_irq_before", {31'd0, bus.irq}, 32'd0);
        idle(1);
        rd_check("t2_count_zero", B + 32'd8, 32'd0);
        check_eq("t2_irq_rise", {31'd0, bus.irq}, 32'd1);
        idle(1);
        rd_check("t2_en_cleared", B, 32'h8);
        idle(3);
        check_eq("t2_irq_held", {31'd0, bus.irq}, 32'd1);
        wr(B, 32'd0);
        check_eq("t2_irq_cleared", {31'd0, bus.irq}, 32'd0);

        // PRESET=0 expires on the first counting cycle
        wr(B + 32'd4, 32'd0); wr(B, 32'h9);
        idle(2);
        check_eq("p0_irq_low", {31'd0, bus.irq}, 32'd0);
        idle(1);
        check_eq("p0_irq_high", {31'd0, bus.irq}, 32'd1);
        wr(B, 32'd0);

        // byte enables and ignored addresses
        wr(B + 32'd4, 32'd0);
        step(1'b1, B + 32'd4, 32'hAABB_CCDD, 4'b0101);
        rd_check("t4_preset_be", B + 32'd4, 32'h00BB_00DD);
        step(1'b1, B + 32'd8, 32'h0000_1234, 4'hF);
        step(1'b1, B + 32'd12, 32'hFFFF_FFFF, 4'hF);
        step(1'b1, B + 32'd16, 32'hFFFF_FFFF, 4'hF);
        rd_check("t4_count_ro", B + 32'd8, 32'd0);
        rd_check("t4_reserved", B + 32'd12, 32'd0);
        rd_check("t4_out_of_range", B + 32'd16, 32'd0);
        rd_check("t4_preset_kept", B + 32'd4, 32'h00BB_00DD);
        rd_check("t4_ctrl_kept", B, 32'd0);

        // auto-reload, PRESET=3
        wr(B, 32'd0); wr(B + 32'd4, 32'd3); wr(B, 32'hB);
        pulses.delete();
        for (int k = 1; k <= 4 + 3 * P + 4 * (3 * P + 2); k++) begin
            idle(1);
            if (bus.irq) pulses.push_back(k);
        end
        check_eq("t3_first_pulse", (pulses.size() > 0) ? pulses[0] : 0, 2 + 3 * P);
        check_eq("t3_pulse_count", pulses.size(), 5);
        for (int j = 1; j < pulses.size(); j++)
            check_eq("t3_period", pulses[j] - pulses[j-1], 3 * P + 2);
        rd_check("t3_ctrl_en", B, 32'hB);

        // asynchronous reset while irq is high
        for (int k = 0; k < 40 && !m_pend; k++) idle(1);
        check_eq("t1_irq_pre", {31'd0, bus.irq}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("t1_irq_async", {31'd0, bus.irq}, 32'd0);
        model_reset();
        rd_check("t1_ctrl", B, 32'd0);
        rd_check("t1_preset", B + 32'd4, 32'd0);
        rd_check("t1_count", B + 32'd8, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // PRESET write during CNT only affects the next reload
        wr(B, 32'd0); wr(B + 32'd4, 32'd2); wr(B, 32'hB);
        idle(2);
        rd_check("t5_count_start", B + 32'd8, 32'd2);
        wr(B + 32'd4, 32'd7);
        idle(2 * P - 1);
        check_eq("t5_irq_old_period", {31'd0, bus.irq}, 32'd1);
        idle(2);
        rd_check("t5_count_reload", B + 32'd8, 32'd7);

        // one-shot CTRL write in the INT cycle keeps EN and restarts
        wr(B, 32'd0); wr(B + 32'd4, 32'd2); wr(B, 32'h9);
        idle(2 * P + 2);
        check_eq("t5_int_irq", {31'd0, bus.irq}, 32'd1);
        wr(B, 32'h9);
        check_eq("t5_pending_clr", {31'd0, bus.irq}, 32'd0);
        rd_check("t5_en_kept", B, 32'h9);
        idle(2);
        rd_check("t5_restart", B + 32'd8, 32'd2);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin : rnd
            logic        w;
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  b;
            int          pick;
            pick = $urandom_range(0, 7);
            case (pick)
                0, 6:    a = B;
                1, 7:    a = B + 32'd4;
                2:       a = B + 32'd8;
                3:       a = B + 32'd12;
                4:       a = B + 32'd16;
                default: a = B - 32'd16;
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 9) < 2);
            if (a[31:4] == B[31:4] && a[3:2] == 2'd0) begin
                d = $urandom;
                d[0] = ($urandom_range(0, 3) != 0);
                d[3] = ($urandom_range(0, 3) != 0);
            end else if (a[31:4] == B[31:4] && a[3:2] == 2'd1) begin
                d = $urandom_range(0, 6);
            end else begin
                d = $urandom;
            end
            b = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            step(w, a, d, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
